// File: rtl/stack_calc_pkg.sv
// Shared types and helpers for the stack_calc operand-stack datapath.
package stack_calc_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b011,
    OP_DUP  = 3'b100,
    OP_SWAP = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Signed add/sub overflow from the sign bits of S, T and the truncated result.
  function automatic logic addsub_ovf(input logic sub, input logic s_sign,
                                      input logic t_sign, input logic r_sign);
    addsub_ovf = (sub ? (s_sign != t_sign) : (s_sign == t_sign)) && (r_sign != s_sign);
  endfunction

endpackage

// File: rtl/stack_mul_seq.sv
// Radix-2 shift-add signed multiplier with a fixed WIDTH-cycle latency.
module stack_mul_seq
  import stack_calc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy;
  logic               neg;
  logic [CW-1:0]      iter;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  assign acc_nx  = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (iter == CW'(WIDTH - 1));
  // Product reflects the final accumulation so the caller can write back on the done edge.
  assign product = neg ? (~acc_nx + 1'b1) : acc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      neg    <= 1'b0;
      iter   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      neg    <= a[WIDTH-1] ^ b[WIDTH-1];
      iter   <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
    end else if (busy) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/stack_calc.sv
// Stack-machine arithmetic unit: operand stack, command FSM, result registers.
module stack_calc
  import stack_calc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [2:0]             opcode,
  input  logic [WIDTH-1:0]       op_data,
  output logic                   result_valid,
  output logic [WIDTH-1:0]       result_data,
  output logic                   overflow,
  output logic                   error,
  output logic [WIDTH-1:0]       top_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt, cnt_nx;
  state_e           state, state_nx;
  opcode_e          op;

  logic [AW-1:0]    idx_t, idx_s, idx_p;
  logic [WIDTH-1:0] t, s, sum, diff;
  logic             has1, has2;

  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_idx, wr1_idx;
  logic [WIDTH-1:0] wr0_data, wr1_data;

  logic             res_v_nx, ovf_nx, err_nx;
  logic [WIDTH-1:0] res_d_nx;

  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH:0]     mul_hi;

  assign op    = opcode_e'(opcode);
  assign idx_t = AW'(cnt - CW'(1));
  assign idx_s = AW'(cnt - CW'(2));
  assign idx_p = AW'(cnt);
  assign t     = mem[idx_t];
  assign s     = mem[idx_s];
  assign sum   = s + t;
  assign diff  = s - t;
  assign has1  = (cnt >= CW'(1));
  assign has2  = (cnt >= CW'(2));

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign top_data = empty ? '0 : t;
  assign op_ready = (state == IDLE);
  assign mul_hi   = mul_p[2*WIDTH-1:WIDTH-1];

  stack_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (s),
    .b       (t),
    .done    (mul_done),
    .product (mul_p)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wr0_en    = 1'b0;
    wr0_idx   = idx_s;
    wr0_data  = '0;
    wr1_en    = 1'b0;
    wr1_idx   = idx_t;
    wr1_data  = '0;
    res_v_nx  = 1'b0;
    res_d_nx  = '0;
    ovf_nx    = 1'b0;
    err_nx    = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          res_v_nx = 1'b1;
          case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB: begin
              if (has2) begin
                wr0_en   = 1'b1;
                wr0_data = (op == OP_SUB) ? diff : sum;
                res_d_nx = wr0_data;
                ovf_nx   = addsub_ovf(op == OP_SUB, s[WIDTH-1], t[WIDTH-1], wr0_data[WIDTH-1]);
                cnt_nx   = cnt - CW'(1);
              end else err_nx = 1'b1;
            end
            OP_MUL: begin
              if (has2) begin
                res_v_nx  = 1'b0;
                mul_start = 1'b1;
                state_nx  = MUL;
              end else err_nx = 1'b1;
            end
            OP_DUP: begin
              if (has1 && !full) begin
                wr0_en   = 1'b1;
                wr0_idx  = idx_p;
                wr0_data = t;
                res_d_nx = t;
                cnt_nx   = cnt + CW'(1);
              end else err_nx = 1'b1;
            end
            OP_SWAP: begin
              if (has2) begin
                wr0_en   = 1'b1;
                wr0_data = t;
                wr1_en   = 1'b1;
                wr1_data = s;
                res_d_nx = s;
              end else err_nx = 1'b1;
            end
            OP_PUSH: begin
              if (!full) begin
                wr0_en   = 1'b1;
                wr0_idx  = idx_p;
                wr0_data = op_data;
                res_d_nx = op_data;
                cnt_nx   = cnt + CW'(1);
              end else err_nx = 1'b1;
            end
            OP_POP: begin
              if (has1) begin
                res_d_nx = t;
                cnt_nx   = cnt - CW'(1);
              end else err_nx = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (mul_done) begin
          wr0_en   = 1'b1;
          wr0_data = mul_p[WIDTH-1:0];
          res_v_nx = 1'b1;
          res_d_nx = mul_p[WIDTH-1:0];
          ovf_nx   = !((&mul_hi) || !(|mul_hi));
          cnt_nx   = cnt - CW'(1);
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr0_idx] <= wr0_data;
    if (wr1_en) mem[wr1_idx] <= wr1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      overflow     <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      result_valid <= res_v_nx;
      result_data  <= res_d_nx;
      overflow     <= ovf_nx;
      error        <= err_nx;
    end
  end

endmodule
